reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised successor to the single-cycle register file, for the pipelined core. It provides:
- Two combinational read ports and one write-back port.
- A per-register scoreboard of pending writes, driving issue stall (RAW and WAW hazards).
- A pending-write counter and a flush input for pipeline squash.

It sits between decode/issue and write-back.

Parameters:
- XLEN, 32, data width of each register.
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W.
- SP_IDX, 2, index of the stack pointer register.
- SP_INIT, 32'h0101_1111, reset value of register SP_IDX. Truncated or zero-extended to XLEN.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- rs1_addr  input  ADDR_W  read port 1 index.
- rs2_addr  input  ADDR_W  read port 2 index.
- rs1_data  output  XLEN  read port 1 data (combinational).
- rs2_data  output  XLEN  read port 2 data (combinational).
- rs1_busy  output  1  rs1 has an outstanding write.
- rs2_busy  output  1  rs2 has an outstanding write.
- issue_valid  input  1  instruction using rs1/rs2 wants to issue.
- issue_we  input  1  issuing instruction writes a destination.
- issue_rd  input  ADDR_W  destination of issuing instruction.
- stall  output  1  issue blocked this cycle.
- wb_valid  input  1  write-back valid.
- wb_rd  input  ADDR_W  write-back index.
- wb_data  input  XLEN  write-back data.
- flush  input  1  clear all pending-write marks.
- pending_cnt  output  ADDR_W+1  number of set scoreboard bits.

Behaviour:
- Reset (async, reset_n low):
  - All registers become 0, except reg[SP_IDX] = SP_INIT.
  - busy[] becomes all 0 and pending_cnt becomes 0.
  - Reads return these values immediately, with no clock needed.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and issues targeting it do not modify state or the scoreboard.
- Reads: rsN_data = reg[rsN_addr], combinational. There is no bypass unless the optional feature is enabled.
- Write: on posedge, if wb_valid && wb_rd != 0, then reg[wb_rd] <= wb_data and busy[wb_rd] <= 0.
- Effective busy: wbclr[r] = wb_valid && wb_rd == r; beff[r] = busy[r] && !wbclr[r].
- rsN_busy = busy[rsN_addr], using the raw value (this becomes beff with the bypass enabled). It is 0 for index 0.
- stall = issue_valid && (rs1_busy || rs2_busy || (issue_we && issue_rd != 0 && beff[issue_rd])).
  - rs1_busy and rs2_busy cover RAW hazards.
  - The beff[issue_rd] term covers WAW.
- Issue accepted when issue_valid && !stall && !flush:
  - If issue_we && issue_rd != 0, then busy[issue_rd] <= 1.
- Same-edge set and clear of the same index: set wins.
- Write-back to a non-busy register: data is written, busy stays 0, and pending_cnt is unchanged.
- flush:
  - busy[] <= all 0 and pending_cnt <= 0 at the next edge.
  - A write-back in the same cycle still writes its data.
  - Any issue in that cycle is not accepted; stall still reflects the formula.
- pending_cnt:
  - +1 on an accepted issue that sets a bit.
  - -1 on a write-back that clears a set bit.
  - Both in the same cycle: unchanged.
  - Never wraps, since at most NUM_REGS-1 bits can be set.
- Latency:
  - Write data is visible on reads the cycle after the write edge.
  - busy changes become visible the cycle after the edge.

Optional Feature:
REG_FILE_BYPASS_EN
- Defined:
  - If wb_valid && wb_rd == rsN_addr && rsN_addr != 0, then rsN_data = wb_data in the same cycle.
  - rsN_busy uses beff, so an instruction waiting on that write-back issues in the same cycle.
- Undefined:
  - Reads return stored contents only.
  - rsN_busy uses raw busy, so a dependent instruction issues one cycle after the write-back.

Test Plan:
- Reset mid-run with x5 = 7 and busy[5] = 1; drop reset_n asynchronously.
  - Immediately: rs1_addr=2 reads 32'h0101_1111, rs1_addr=5 reads 0, pending_cnt = 0.
- wb_valid=1, wb_rd=0, wb_data=32'hDEAD_BEEF; issue_rd=0 with issue_we=1.
  - x0 still reads 0, rs1_busy = 0, pending_cnt = 0.
- Issue rd=3 (accepted). Next cycle, issue with rs1_addr=3.
  - stall = 1.
  - wb rd=3, data=32'h55: next cycle the read returns 32'h55 and stall = 0.
  - With BYPASS_EN: stall = 0 and rs1_data = 32'h55 in the write-back cycle itself.
- Issue rd=4 while busy[4] = 1 and no write-back.
  - stall = 1 (WAW).
  - Same cycle with wb rd=4: stall = 0, and busy[4] stays 1 (set wins); pending_cnt unchanged.
- Issue rd=6, 7, 8 over three cycles.
  - pending_cnt reaches 3.
  - Then flush together with wb rd=9, data=32'h1: pending_cnt = 0, all busy = 0, x9 reads 32'h1.
- Random issue/wb sequence of 1000 cycles.
  - pending_cnt equals the popcount of busy[] every cycle.
  - Register contents match a reference model.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with a per-register pending-write scoreboard for issue stall (RAW/WAW).
// Optional same-cycle write-back bypass on the read ports: define REG_FILE_BYPASS_EN.
module reg_file_sb #(
    parameter int          XLEN    = 32,
    parameter int          ADDR_W  = 5,
    parameter int          SP_IDX  = 2,
    parameter logic [31:0] SP_INIT = 32'h0101_1111
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              stall,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int              NUM_REGS = 2 ** ADDR_W;
    localparam logic [XLEN-1:0] SP_RESET = XLEN'(SP_INIT);

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
        onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     cnt_d;

    logic [NUM_REGS-1:0] wbclr_s;
    logic [NUM_REGS-1:0] beff_s;
    logic                wb_wr_s;
    logic                set_en_s;
    logic                clr_en_s;
    logic [NUM_REGS-1:0] set_vec_s;
    logic [NUM_REGS-1:0] clr_vec_s;

    assign wb_wr_s   = wb_valid && (wb_rd != {ADDR_W{1'b0}});
    assign wbclr_s   = wb_valid ? onehot(wb_rd) : {NUM_REGS{1'b0}};
    assign beff_s    = busy_q & ~wbclr_s;
    // A write-back only retires a pending mark if one is actually outstanding.
    assign clr_en_s  = wb_wr_s && busy_q[wb_rd];
    assign set_en_s  = issue_valid && !stall && !flush && issue_we && (issue_rd != {ADDR_W{1'b0}});
    assign set_vec_s = set_en_s ? onehot(issue_rd) : {NUM_REGS{1'b0}};
    assign clr_vec_s = clr_en_s ? onehot(wb_rd) : {NUM_REGS{1'b0}};
    assign pending_cnt = cnt_q;

    // Read ports: stored contents (index 0 is never written, so it stays zero).
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        rs2_data = regs_q[rs2_addr];
`ifdef REG_FILE_BYPASS_EN
        if (wb_wr_s && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
        if (wb_wr_s && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
`endif
    end

    // Source-operand busy flags and the issue stall decision.
    always_comb begin
`ifdef REG_FILE_BYPASS_EN
        rs1_busy = beff_s[rs1_addr];
        rs2_busy = beff_s[rs2_addr];
`else
        rs1_busy = busy_q[rs1_addr];
        rs2_busy = busy_q[rs2_addr];
`endif
        stall = issue_valid &&
                (rs1_busy || rs2_busy ||
                 (issue_we && (issue_rd != {ADDR_W{1'b0}}) && beff_s[issue_rd]));
    end

    // Register array next state from the write-back port.
    always_comb begin
        regs_d = regs_q;
        if (wb_wr_s) begin
            regs_d[wb_rd] = wb_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Scoreboard next state: clear then set, so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (flush) begin
            busy_d = {NUM_REGS{1'b0}};
            cnt_d  = {(ADDR_W+1){1'b0}};
        end else begin
            busy_d = (busy_q & ~clr_vec_s) | set_vec_s;
            case ({set_en_s, clr_en_s})
                2'b10:   cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                2'b01:   cnt_d = cnt_q - {{ADDR_W{1'b0}}, 1'b1};
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers with asynchronous reset; the stack pointer has a non-zero reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RESET : {XLEN{1'b0}};
            end
            busy_q <= {NUM_REGS{1'b0}};
            cnt_q  <= {(ADDR_W+1){1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed hazard scenarios plus a randomized run
// checked against an array-based reference model of the register file and scoreboard.
module tb_reg_file_sb;

    localparam logic [31:0] SP_VAL = 32'h0101_1111;

    logic        clk;
    logic        reset_n;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        rs1_busy, rs2_busy, issue_valid, issue_we, stall, wb_valid, flush;
    logic [5:0]  pending_cnt;

    reg_file_sb dut (
        .clk(clk), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] name;
        logic [31:0]  d1;
        logic [31:0]  d2;
        logic         b1;
        logic         b2;
        logic         st;
        logic [5:0]   cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = (i == 2) ? SP_VAL : 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (wb_valid && wb_rd == a) return wb_data;
`endif
        return m_reg[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
        if (wb_valid && wb_rd == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic exp_t model_exp(input logic [127:0] nm);
        exp_t e;
        int   pc;
        logic waw;
        e.name = nm;
        e.d1   = model_read(rs1_addr);
        e.d2   = model_read(rs2_addr);
        e.b1   = model_busy(rs1_addr);
        e.b2   = model_busy(rs2_addr);
        waw    = issue_we && issue_rd != 5'd0 && m_busy[issue_rd] &&
                 !(wb_valid && wb_rd == issue_rd);
        e.st   = issue_valid && (e.b1 || e.b2 || waw);
        pc = 0;
        for (int i = 0; i < 32; i++) pc += int'(m_busy[i]);
        e.cnt  = 6'(pc);
        return e;
    endfunction

    task automatic model_edge();
        exp_t e;
        bit   acc;
        e   = model_exp("edge");
        acc = issue_valid && !e.st && !flush;
        if (wb_valid && wb_rd != 5'd0) begin
            m_reg[wb_rd]  = wb_data;
            m_busy[wb_rd] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (acc && issue_we && issue_rd != 5'd0) begin
            m_busy[issue_rd] = 1'b1;
        end
    endtask

    // Inputs are already driven; snapshot the expectation, let the clock edge happen, advance the model.
    task automatic cycle(input logic [127:0] nm);
        exp_q.push_back(model_exp(nm));
        @(posedge clk);
        if (reset_n) model_edge();
        else model_reset();
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; flush = 1'b0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    task automatic check(input logic [127:0] nm, input string fld,
                         input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %0s.%0s got %h want %h at %0t", nm, fld, act, want, $time);
        end
    endtask

    exp_t me;
    // Monitor: outputs are sampled mid-cycle, one expectation per driven cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            check(me.name, "rs1_data", rs1_data, me.d1);
            check(me.name, "rs2_data", rs2_data, me.d2);
            check(me.name, "rs1_busy", {31'h0, rs1_busy}, {31'h0, me.b1});
            check(me.name, "rs2_busy", {31'h0, rs2_busy}, {31'h0, me.b2});
            check(me.name, "stall", {31'h0, stall}, {31'h0, me.st});
            check(me.name, "pending_cnt", {26'h0, pending_cnt}, {26'h0, me.cnt});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rs1_addr = 5'd2; rs2_addr = 5'd5;
        cycle("rst_init");
        reset_n = 1'b1;

        // Register 0 write/issue must not change anything.
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd0;
        cycle("x0_write");
        idle();
        cycle("x0_read");

        // RAW on x3.
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd1; rs2_addr = 5'd1;
        cycle("iss3");
        issue_we = 1'b0; issue_rd = 5'd0; rs1_addr = 5'd3; rs2_addr = 5'd0;
        cycle("raw_stall");
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
        cycle("raw_wb");
        wb_valid = 1'b0;
        cycle("raw_after");

        // WAW on x4, then same-edge set/clear.
        idle();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd4;
        cycle("iss4");
        cycle("waw_stall");
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        cycle("waw_wb");
        idle();
        rs1_addr = 5'd4;
        cycle("waw_after");

        // Retire x4, then three issues and a flush with a concurrent write-back.
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h4;
        cycle("wb4");
        idle();
        issue_valid = 1'b1; issue_we = 1'b1;
        for (int r = 6; r <= 8; r++) begin
            issue_rd = 5'(r);
            cycle("iss678");
        end
        flush = 1'b1; issue_rd = 5'd10;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h1;
        rs1_addr = 5'd6; rs2_addr = 5'd7;
        cycle("flush");
        idle();
        rs1_addr = 5'd9; rs2_addr = 5'd6;
        cycle("post_flush");

        // Mid-run reset with x5 = 7 and busy[5] set.
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h7;
        cycle("wb5");
        idle();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5;
        cycle("iss5");
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        cycle("busy5");
        reset_n = 1'b0;
        model_reset();
        rs1_addr = 5'd2; rs2_addr = 5'd5;
        cycle("rst_mid");
        reset_n = 1'b1;
        cycle("rst_rel");

        // Randomized traffic.
        for (int c = 0; c < 1000; c++) begin
            rs1_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
            rs2_addr    = 5'($urandom_range(0, 9));
            issue_valid = 1'($urandom_range(0, 1));
            issue_we    = ($urandom_range(0, 3) != 0);
            issue_rd    = 5'($urandom_range(0, 9));
            wb_valid    = ($urandom_range(0, 2) != 0);
            wb_rd       = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
            wb_data     = $urandom;
            flush       = ($urandom_range(0, 49) == 0);
            cycle("random");
        end

        idle();
        @(negedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
